// File: rtl/hbridge_pkg.sv
// Shared state codes, gate patterns and bit positions for the H-bridge sequencer.
package hbridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BOOT  = 3'd1,
        ST_GAP_A = 3'd2,
        ST_PRECH = 3'd3,
        ST_GAP_B = 3'd4,
        ST_RUN   = 3'd5,
        ST_FAULT = 3'd7
    } state_t;

    // Gate words are {Q4,Q3,Q2,Q1}
    localparam logic [3:0] Q_OFF   = 4'b0000;
    localparam logic [3:0] Q_BOOT  = 4'b1100;
    localparam logic [3:0] Q_PRECH = 4'b1001;

    localparam int Q1_IDX = 0;
    localparam int Q2_IDX = 1;
    localparam int Q3_IDX = 2;
    localparam int Q4_IDX = 3;

    // Q1/Q3 share one leg, Q2/Q4 the other; both on in a leg shorts the rail.
    function automatic logic is_shoot_through(input logic [3:0] q);
        return (q[Q1_IDX] & q[Q3_IDX]) | (q[Q2_IDX] & q[Q4_IDX]);
    endfunction

endpackage

// File: rtl/hbridge_sequencer_phase_timer.sv
// Phase timer: counts cycles since the last clear, holds at limit-1 so it never wraps.
module phase_timer #(
    parameter int CNT_W = 20
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_done
);

    logic [CNT_W-1:0] cnt;

    assign o_done = (cnt == i_limit - CNT_W'(1));

    // Count up from zero after a clear, stop once the terminal value is reached
    always_ff @(posedge i_CLK) begin
        if (i_RST || i_clear) begin
            cnt <= '0;
        end else if (!o_done) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hbridge_sequencer.sv
// H-bridge start-up / run / fault sequencer sitting between the controller gate word and the pins.
//
// state   | meaning
// IDLE    | all gates off, waiting for enable
// BOOT    | low sides on, charging bootstrap caps
// GAP_A   | all-off gap before pre-charge
// PRECH   | Q1+Q4 on, pre-charging tank in sigma=1
// GAP_B   | all-off gap before handing over
// RUN     | controller word passed through, controller out of reset
// FAULT   | latched all-off until hold time elapsed and enable dropped
module hbridge_sequencer
    import hbridge_pkg::*;
#(
    parameter int T_BOOT       = 1000,
    parameter int T_PRECH      = 600,
    parameter int DEADTIME     = 8,
    parameter int T_FAULT_HOLD = 100000,
    parameter int CNT_W        = 20
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_enable,
    input  logic [3:0] i_Q_ctrl,
    input  logic       i_fault_ext,
    output logic [3:0] o_Q,
    output logic       o_ctrl_rst,
    output logic       o_fault,
    output logic [2:0] o_state
);

    localparam logic [CNT_W-1:0] LIM_BOOT  = CNT_W'(T_BOOT);
    localparam logic [CNT_W-1:0] LIM_PRECH = CNT_W'(T_PRECH);
    localparam logic [CNT_W-1:0] LIM_GAP   = CNT_W'(DEADTIME);
    localparam logic [CNT_W-1:0] LIM_FAULT = CNT_W'(T_FAULT_HOLD);

    state_t           state_q;
    state_t           state_nxt;
    state_t           state_cand;
    logic [CNT_W-1:0] limit;
    logic             done;
    logic             fault_hit;
    logic [3:0]       q_nxt;
    logic [3:0]       q_reg;
    logic             ctrl_rst_q;
    logic             fault_q;

    // Phase length for the state currently being timed
    always_comb begin
        limit = CNT_W'(1);
        case (state_q)
            ST_BOOT:  limit = LIM_BOOT;
            ST_GAP_A: limit = LIM_GAP;
            ST_PRECH: limit = LIM_PRECH;
            ST_GAP_B: limit = LIM_GAP;
            ST_FAULT: limit = LIM_FAULT;
            default:  limit = CNT_W'(1);
        endcase
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .i_clear (state_nxt != state_q),
        .i_limit (limit),
        .o_done  (done)
    );

    // Next state and next output word; faults override enable, enable overrides timers
    always_comb begin
        state_cand = state_q;
        state_nxt  = state_q;
        q_nxt      = Q_OFF;
        if (state_q == ST_FAULT) begin
            state_cand = (done && !i_enable) ? ST_IDLE : ST_FAULT;
        end else if (!i_enable) begin
            state_cand = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_cand = ST_BOOT;
                ST_BOOT:  state_cand = done ? ST_GAP_A : ST_BOOT;
                ST_GAP_A: state_cand = done ? ST_PRECH : ST_GAP_A;
                ST_PRECH: state_cand = done ? ST_GAP_B : ST_PRECH;
                ST_GAP_B: state_cand = done ? ST_RUN : ST_GAP_B;
                ST_RUN:   state_cand = ST_RUN;
                default:  state_cand = ST_IDLE;
            endcase
        end
        // Also screen the word on RUN entry so an illegal word can never be latched into o_Q
        fault_hit = i_fault_ext
                  | (is_shoot_through(i_Q_ctrl) & ((state_q == ST_RUN) | (state_cand == ST_RUN)));
        state_nxt = fault_hit ? ST_FAULT : state_cand;
        case (state_nxt)
            ST_BOOT:  q_nxt = Q_BOOT;
            ST_PRECH: q_nxt = Q_PRECH;
            ST_RUN:   q_nxt = i_Q_ctrl;
            default:  q_nxt = Q_OFF;
        endcase
    end

    // State register and outputs decoded from next state so they move together
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q    <= ST_IDLE;
            q_reg      <= Q_OFF;
            ctrl_rst_q <= 1'b1;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            q_reg      <= q_nxt;
            ctrl_rst_q <= (state_nxt != ST_RUN);
            fault_q    <= (state_nxt == ST_FAULT);
        end
    end

    assign o_Q        = q_reg;
    assign o_ctrl_rst = ctrl_rst_q;
    assign o_fault    = fault_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_hbridge_sequencer.sv
// Self-checking bench: directed sequences with literal expectations plus a randomized run
// compared every cycle against a behavioural model of the sequencing rules.
module tb_hbridge_sequencer;

    localparam int TB   = 10;
    localparam int TP   = 6;
    localparam int DT   = 2;
    localparam int HOLD = 20;

    localparam int PAT_OFF   = 0;
    localparam int PAT_BOOT  = 12;
    localparam int PAT_PRECH = 9;

    logic       i_CLK = 1'b0;
    logic       i_RST;
    logic       i_enable;
    logic [3:0] i_Q_ctrl;
    logic       i_fault_ext;
    logic [3:0] o_Q;
    logic       o_ctrl_rst;
    logic       o_fault;
    logic [2:0] o_state;

    int errors = 0;
    int checks = 0;

    hbridge_sequencer #(
        .T_BOOT       (TB),
        .T_PRECH      (TP),
        .DEADTIME     (DT),
        .T_FAULT_HOLD (HOLD),
        .CNT_W        (8)
    ) dut (
        .i_CLK       (i_CLK),
        .i_RST       (i_RST),
        .i_enable    (i_enable),
        .i_Q_ctrl    (i_Q_ctrl),
        .i_fault_ext (i_fault_ext),
        .o_Q         (o_Q),
        .o_ctrl_rst  (o_ctrl_rst),
        .o_fault     (o_fault),
        .o_state     (o_state)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic illegal(input logic [3:0] w);
        return (w[0] & w[2]) | (w[1] & w[3]);
    endfunction

    function automatic logic [3:0] legal_word();
        logic [3:0] w;
        do w = 4'($urandom_range(0, 15)); while (illegal(w));
        return w;
    endfunction

    // Behavioural model: phase index plus cycles spent in it
    int         m_st    = 0;
    int         m_age   = 0;
    logic       m_valid = 1'b0;
    logic [3:0] m_q     = 4'b0;

    always @(posedge i_CLK) begin
        int cand;
        int nst;
        if (i_RST) begin
            m_st    = 0;
            m_age   = 0;
            m_valid = 1'b1;
        end else begin
            if (m_st == 7)
                cand = (m_age >= HOLD - 1 && !i_enable) ? 0 : 7;
            else if (!i_enable)
                cand = 0;
            else begin
                case (m_st)
                    0:       cand = 1;
                    1:       cand = (m_age == TB - 1) ? 2 : 1;
                    2:       cand = (m_age == DT - 1) ? 3 : 2;
                    3:       cand = (m_age == TP - 1) ? 4 : 3;
                    4:       cand = (m_age == DT - 1) ? 5 : 4;
                    default: cand = 5;
                endcase
            end
            nst   = (i_fault_ext || (illegal(i_Q_ctrl) && (m_st == 5 || cand == 5))) ? 7 : cand;
            m_age = (nst == m_st) ? m_age + 1 : 0;
            m_st  = nst;
        end
        m_q = (m_st == 1) ? 4'b1100 : (m_st == 3) ? 4'b1001 : (m_st == 5) ? i_Q_ctrl : 4'b0000;
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge i_CLK) begin
        if (m_valid) begin
            check("cycle {state,q,ctrl_rst,fault}",
                  int'({o_state, o_Q, o_ctrl_rst, o_fault}),
                  int'({3'(m_st), m_q, (m_st != 5), (m_st == 7)}));
        end
    end

    task automatic tick();
        @(negedge i_CLK);
    endtask

    initial begin
        int n;
        logic [3:0] w;
        i_RST = 1'b1; i_enable = 1'b0; i_Q_ctrl = 4'b0; i_fault_ext = 1'b0;
        repeat (3) tick();
        check("reset_state", int'(o_state), 0);
        check("reset_q", int'(o_Q), PAT_OFF);
        check("reset_ctrl_rst", int'(o_ctrl_rst), 1);
        check("reset_fault", int'(o_fault), 0);
        i_RST = 1'b0;
        tick();
        check("idle_no_enable", int'(o_state), 0);

        // Nominal start
        i_Q_ctrl = 4'b0110; i_enable = 1'b1;
        for (int i = 0; i < TB; i++) begin tick(); check("boot_q", int'(o_Q), PAT_BOOT); end
        check("boot_ctrl_rst", int'(o_ctrl_rst), 1);
        for (int i = 0; i < DT; i++) begin tick(); check("gap_a_q", int'(o_Q), PAT_OFF); end
        for (int i = 0; i < TP; i++) begin tick(); check("prech_q", int'(o_Q), PAT_PRECH); end
        for (int i = 0; i < DT; i++) begin tick(); check("gap_b_q", int'(o_Q), PAT_OFF); end
        check("gap_b_ctrl_rst", int'(o_ctrl_rst), 1);
        tick();
        check("run_entry_q", int'(o_Q), 6);
        check("run_entry_ctrl_rst", int'(o_ctrl_rst), 0);
        check("run_entry_state", int'(o_state), 5);
        for (int i = 0; i < 40; i++) begin
            w = legal_word();
            i_Q_ctrl = w;
            tick();
            check("run_q_latency", int'(o_Q), int'(w));
        end

        // Shoot-through
        i_Q_ctrl = 4'b0101;
        tick();
        check("shoot_q", int'(o_Q), PAT_OFF);
        check("shoot_state", int'(o_state), 7);
        check("shoot_fault", int'(o_fault), 1);
        i_Q_ctrl = 4'b0000;
        repeat (30) tick();
        check("fault_held_enable_high", int'(o_state), 7);
        i_enable = 1'b0;
        tick();
        check("fault_release", int'(o_state), 0);

        // External fault in IDLE with enable high, then hold timing
        i_enable = 1'b1; i_fault_ext = 1'b1;
        tick();
        check("ext_idle_state", int'(o_state), 7);
        check("ext_idle_fault", int'(o_fault), 1);
        i_fault_ext = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            if (k == 5) i_enable = 1'b0;
            tick();
            check("fault_hold_state", int'(o_state), 7);
        end
        tick();
        check("fault_hold_exit", int'(o_state), 0);

        // Enable drop during PRECH, then full restart
        i_enable = 1'b1;
        repeat (TB + DT + 3) tick();
        check("in_prech", int'(o_state), 3);
        i_enable = 1'b0;
        tick();
        check("drop_state", int'(o_state), 0);
        check("drop_q", int'(o_Q), PAT_OFF);
        check("drop_ctrl_rst", int'(o_ctrl_rst), 1);
        i_enable = 1'b1;
        n = 0;
        tick();
        while (o_Q == 4'b1100 && n < 50) begin n++; tick(); end
        check("restart_boot_len", n, TB);
        check("restart_gap_a", int'(o_state), 2);

        // Reset during BOOT
        i_enable = 1'b0; tick();
        i_enable = 1'b1; repeat (3) tick();
        i_RST = 1'b1;
        tick();
        check("rst_mid_state", int'(o_state), 0);
        check("rst_mid_q", int'(o_Q), PAT_OFF);
        check("rst_mid_ctrl_rst", int'(o_ctrl_rst), 1);
        check("rst_mid_fault", int'(o_fault), 0);
        i_RST = 1'b0; i_enable = 1'b0;
        tick();

        // Priority: fault, enable drop and BOOT expiry on one edge
        i_enable = 1'b1;
        tick();
        repeat (TB - 1) tick();
        check("prio_pre_state", int'(o_state), 1);
        i_fault_ext = 1'b1; i_enable = 1'b0;
        tick();
        check("prio_state", int'(o_state), 7);
        i_fault_ext = 1'b0;
        n = 0;
        while (o_state != 3'd0 && n < 60) begin tick(); n++; end
        check("prio_fault_exit_cycles", n, HOLD);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            i_RST = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 149) == 0) i_enable = ~i_enable;
            i_fault_ext = ($urandom_range(0, 399) == 0);
            i_Q_ctrl = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(0, 15)) : legal_word();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
